// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO write port.
// Round-robin grants with bounded bursts. Writes are throttled by the
// FIFO fill level and the full flag, so no beat ever reaches a full FIFO.
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int MAX_BURST     = 4
) (
  input  logic                            wclk,
  input  logic                            hw_rst,
  input  logic                            sw_wrst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            wfull,
  input  logic [ADDRESS_WIDTH:0]          wfill,
  input  logic                            wr_overflow,
  output logic                            winc,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy,
  output logic                            err_hold
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int BW    = $clog2(MAX_BURST + 1);
  localparam int FW    = ADDRESS_WIDTH + 2;
  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic [FW-1:0]   fill_sum;
  logic            space_ok;
  logic            can_write;
  logic            cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic            accept;
  logic            last_beat;
  logic [IDW-1:0]  next_ptr;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;

  // winc stands for the one beat in flight that wfill does not show yet.
  assign fill_sum  = {1'b0, wfill} + FW'(winc);
  assign space_ok  = fill_sum < FW'(DEPTH);
  assign can_write = space_ok & ~wfull & ~wr_overflow;

  assign cur_valid = req_valid[grant_id];
  assign cur_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state == BURST) & cur_valid & can_write;
  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));
  assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign req_ready = ((state == BURST) && can_write) ? grant : '0;
  assign busy      = (state != IDLE);

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  // Arbitration FSM and registered FIFO write port.
  always_ff @(posedge wclk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (hw_rst || sw_wrst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      winc     <= 1'b0;
      wdata    <= '0;
      grant    <= '0;
      grant_id <= '0;
      err_hold <= 1'b0;
    end else begin
      winc <= 1'b0;
      if (wr_overflow) begin
        state    <= HOLD;
        grant    <= '0;
        err_hold <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pick_found) begin
              state    <= BURST;
              grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
              grant_id <= pick_id;
              beat_cnt <= '0;
            end
          end
          BURST: begin
            if (accept) begin
              winc     <= 1'b1;
              wdata    <= cur_data;
              beat_cnt <= beat_cnt + 1'b1;
              if (last_beat) begin
                state  <= IDLE;
                grant  <= '0;
                rr_ptr <= next_ptr;
              end
            end else if (!cur_valid) begin
              state  <= IDLE;
              grant  <= '0;
              rr_ptr <= next_ptr;
            end
          end
          HOLD: begin
            // Frozen until a reset or soft flush.
          end
          default: begin
            state <= IDLE;
            grant <= '0;
          end
        endcase
      end
    end
  end

endmodule
